// File: rtl/basic_fifo_pkg.sv
// Shared sizing defaults and the head-of-queue source selector used by basic_fifo.
package basic_fifo_pkg;

  localparam int unsigned BF_DATA_WIDTH = 8;
  localparam int unsigned BF_ADDR_WIDTH = 16;
  localparam int unsigned BF_DATA_DEPTH = 65536;

  typedef enum logic [1:0] {
    HEAD_HOLD  = 2'd0,
    HEAD_DIN   = 2'd1,
    HEAD_RAM   = 2'd2,
    HEAD_EMPTY = 2'd3
  } head_src_e;

endpackage

// File: rtl/basic_fifo_ram.sv
// Simple dual-port storage array: one write port, one registered read port.
module basic_fifo_ram
  import basic_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = BF_ADDR_WIDTH,
  parameter int unsigned DATA_DEPTH = BF_DATA_DEPTH
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read-before-write on address collision; the caller bypasses that case.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/basic_fifo.sv
// First-word-fall-through FIFO: RAM body plus a registered head word on dout.
module basic_fifo
  import basic_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = BF_ADDR_WIDTH,
  parameter int unsigned DATA_DEPTH = BF_DATA_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_vld,
  output logic                  din_rdy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_vld;
  logic                  r_din_rdy;
  logic                  r_byp_vld;
  logic [DATA_WIDTH-1:0] r_byp_data;

  logic                  w_wr;
  logic                  w_rd;
  logic [ADDR_WIDTH:0]   w_ram_cnt;
  logic                  w_ram_empty;
  head_src_e             w_head_src;
  logic                  w_ram_wr;
  logic                  w_ram_rd;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic [DATA_WIDTH-1:0] w_ram_word;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  assign w_wr        = din_vld & r_din_rdy;
  assign w_rd        = r_dout_vld & dout_rdy;
  assign w_ram_cnt   = r_count - {{ADDR_WIDTH{1'b0}}, r_dout_vld};
  assign w_ram_empty = (w_ram_cnt == {(ADDR_WIDTH + 1){1'b0}});

  // Choose where the next head word comes from; din bypasses the RAM when it is empty.
  always_comb begin
    w_head_src = HEAD_HOLD;
    if (!r_dout_vld) begin
      if (w_wr) begin
        w_head_src = HEAD_DIN;
      end else begin
        w_head_src = HEAD_EMPTY;
      end
    end else if (w_rd) begin
      if (!w_ram_empty) begin
        w_head_src = HEAD_RAM;
      end else if (w_wr) begin
        w_head_src = HEAD_DIN;
      end else begin
        w_head_src = HEAD_EMPTY;
      end
    end else begin
      w_head_src = HEAD_HOLD;
    end
  end

  assign w_ram_wr     = w_wr & (w_head_src != HEAD_DIN);
  assign w_ram_rd     = (w_head_src == HEAD_RAM);
  assign w_rd_ptr_nxt = w_ram_rd ? (r_rd_ptr + 1'b1) : r_rd_ptr;
  // RAM read data is stale for one cycle when the word was written at the address being read.
  assign w_ram_word   = r_byp_vld ? r_byp_data : w_ram_rdata;

  // Occupancy update from the two handshakes.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy, head register and write-ready state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr   <= {ADDR_WIDTH{1'b0}};
      r_count    <= {(ADDR_WIDTH + 1){1'b0}};
      r_dout     <= {DATA_WIDTH{1'b0}};
      r_dout_vld <= 1'b0;
      r_din_rdy  <= 1'b0;
      r_byp_vld  <= 1'b0;
      r_byp_data <= {DATA_WIDTH{1'b0}};
    end else begin
      if (w_ram_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_din_rdy  <= (w_count_nxt < DEPTH_C);
      r_byp_vld  <= w_ram_wr & (r_wr_ptr == w_rd_ptr_nxt);
      r_byp_data <= din;
      case (w_head_src)
        HEAD_DIN: begin
          r_dout     <= din;
          r_dout_vld <= 1'b1;
        end
        HEAD_RAM: begin
          r_dout     <= w_ram_word;
          r_dout_vld <= 1'b1;
        end
        HEAD_EMPTY: r_dout_vld <= 1'b0;
        default:    r_dout_vld <= r_dout_vld;
      endcase
    end
  end

  basic_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_wr_en (w_ram_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (w_rd_ptr_nxt),
    .o_rdata (w_ram_rdata)
  );

  assign din_rdy  = r_din_rdy;
  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign count    = r_count;

endmodule

// File: tb/tb_basic_fifo.sv
// Scoreboard bench for basic_fifo (depth 16): a queue model checks every cycle.
module tb_basic_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic          din_rdy;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy = 1'b0;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_q[$];
  logic rst_seen = 1'b1;
  logic stream_mode = 1'b0;

  basic_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_seen <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the queue model, then apply this cycle's transfers to it.
  always @(negedge clk) begin
    int  sz;
    bit  wr_ok;
    bit  rd_ok;
    sz = model_q.size();
    if (rst_seen) begin
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_dout_vld", 32'(dout_vld), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_din_rdy", 32'(din_rdy), 32'd0);
    end else begin
      chk("count", 32'(count), 32'(sz));
      chk("dout_vld", 32'(dout_vld), 32'(sz > 0));
      chk("din_rdy", 32'(din_rdy), 32'(sz < DEPTH));
      if (sz > 0) chk("dout", 32'(dout), 32'(model_q[0]));
      if (stream_mode) chk("stream_count_le2", 32'(count <= 2), 32'd1);
    end
    if (rst) begin
      model_q.delete();
    end else begin
      wr_ok = din_vld && !rst_seen && (sz < DEPTH);
      rd_ok = dout_rdy && (sz > 0);
      if (rd_ok) void'(model_q.pop_front());
      if (wr_ok) model_q.push_back(din);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset held for three cycles
    rst = 1'b1; din_vld = 1'b0; dout_rdy = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rdy_after_release", 32'(din_rdy), 32'd1);

    // Latency into an empty FIFO, then five stall cycles
    din = 8'hA5; din_vld = 1'b1; dout_rdy = 1'b0;
    cyc(1);
    din_vld = 1'b0; din = 8'h00;
    chk("lat_dout", 32'(dout), 32'hA5);
    chk("lat_vld", 32'(dout_vld), 32'd1);
    chk("lat_count", 32'(count), 32'd1);
    cyc(5);
    chk("stall_dout", 32'(dout), 32'hA5);
    dout_rdy = 1'b1;
    cyc(1);
    chk("drained", 32'(count), 32'd0);

    // Streaming 0x00..0xFF with the consumer always ready
    for (int i = 0; i < 256; i++) begin
      din = 8'(i); din_vld = 1'b1;
      cyc(1);
      stream_mode = 1'b1;
    end
    din_vld = 1'b0;
    cyc(2);
    stream_mode = 1'b0;
    chk("stream_empty", 32'(count), 32'd0);

    // Fill: 17 writes with the consumer stalled
    dout_rdy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      din = 8'(8'h40 + i); din_vld = 1'b1;
      cyc(1);
    end
    din_vld = 1'b0;
    chk("full_count", 32'(count), 32'd16);
    chk("full_rdy", 32'(din_rdy), 32'd0);
    chk("full_head", 32'(dout), 32'h40);
    dout_rdy = 1'b1;
    cyc(1);
    dout_rdy = 1'b0;
    chk("unfull_count", 32'(count), 32'd15);
    chk("unfull_rdy", 32'(din_rdy), 32'd1);
    dout_rdy = 1'b1;
    cyc(16);
    dout_rdy = 1'b0;

    // Randomly interleaved traffic, long enough to wrap the pointers many times
    for (int i = 0; i < 400; i++) begin
      din      = 8'($urandom_range(0, 255));
      din_vld  = ($urandom_range(0, 99) < 60);
      dout_rdy = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
      cyc(1);
    end
    din_vld = 1'b0; dout_rdy = 1'b1;
    cyc(20);
    dout_rdy = 1'b0;

    // Mid-stream reset with five words held
    for (int i = 0; i < 5; i++) begin
      din = 8'(8'h90 + i); din_vld = 1'b1;
      cyc(1);
    end
    din_vld = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_vld", 32'(dout_vld), 32'd0);
    cyc(1);
    din = 8'h3C; din_vld = 1'b1;
    cyc(1);
    din = 8'h77;
    cyc(1);
    din_vld = 1'b0;
    chk("post_rst_first", 32'(dout), 32'h3C);
    dout_rdy = 1'b1;
    cyc(4);
    chk("final_empty", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/basic_fifo.md
BASIC_FIFO -- requirements
Module: basic_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one stored word.
REQ-002 Parameter ADDR_WIDTH, default 16: pointer width.
REQ-003 Parameter DATA_DEPTH, default 65536: capacity in words; SHALL equal 2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 din  input  DATA_WIDTH  write data.
REQ-007 din_vld  input  1  producer has a valid word on din.
REQ-008 din_rdy  output  1  FIFO can accept a word this cycle.
REQ-009 dout  output  DATA_WIDTH  head-of-queue word (first-word-fall-through).
REQ-010 dout_vld  output  1  dout holds a valid word.
REQ-011 dout_rdy  input  1  consumer accepts dout this cycle.
REQ-012 count  output  ADDR_WIDTH+1  words currently held, including any word presented on dout.

Function
REQ-013 Write transfer SHALL occur exactly when din_vld and din_rdy are both high at a rising edge; the word is appended at the tail.
REQ-014 Read transfer SHALL occur exactly when dout_vld and dout_rdy are both high at a rising edge; the head word is removed.
REQ-015 din_rdy SHALL be high iff count < DATA_DEPTH; it SHALL be a registered output and SHALL NOT depend combinationally on din_vld or dout_rdy.
REQ-016 dout_vld SHALL be high iff count > 0; dout SHALL present the oldest stored word.
REQ-017 While dout_vld is high and dout_rdy is low, dout and dout_vld SHALL remain stable.
REQ-018 Write-to-output latency into an empty FIFO SHALL be exactly 1 cycle: a word written at edge N is on dout with dout_vld high after edge N.
REQ-019 After a read, the next word (if count > 1) SHALL appear on dout after the same edge, giving back-to-back reads at 1 word per cycle.
REQ-020 count SHALL update after each edge: +1 on write only, -1 on read only, unchanged on simultaneous write and read or neither.
REQ-021 Simultaneous write and read when count = 1: the read returns the stored word, the written word appears on dout after the edge, and count stays 1.
REQ-022 Full (count = DATA_DEPTH): din_rdy low, din ignored; a read in the same cycle raises din_rdy after the edge.
REQ-023 Empty (count = 0): dout_vld low, dout_rdy ignored, and dout value is don't-care.
REQ-024 Read and write pointers SHALL wrap modulo DATA_DEPTH with no data loss or reordering.
REQ-025 Sustained throughput SHALL be 1 write plus 1 read per cycle.
REQ-026 Storage SHALL be inferable as a simple dual-port RAM with one write port and one read port. The output stage SHALL be a registered prefetch word, so dout does not depend combinationally on RAM read data.

Reset
REQ-027 While rst is high at an edge: pointers = 0, count = 0, dout_vld = 0, din_rdy = 0, and dout = 0.
REQ-028 din_rdy SHALL rise 1 cycle after rst deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all stored words and any in-flight transfer in that cycle. RAM contents need not be cleared.

Structure
REQ-030 No shared package is required; all sizing comes from parameters.
REQ-031 One sub-module, basic_fifo_ram, SHALL hold the DATA_DEPTH x DATA_WIDTH dual-port array with a registered read.
REQ-032 Pointer, count and prefetch-stage control SHALL reside in basic_fifo.

Verification
REQ-033 Reset scenario: hold rst 3 cycles, then release -> count=0, dout_vld=0 and dout=0 during reset, then din_rdy=1 one cycle after release.
REQ-034 Latency scenario: write 0xA5 into an empty FIFO with dout_rdy=0 -> next cycle dout=0xA5, dout_vld=1, count=1; dout stays 0xA5 over 5 stall cycles.
REQ-035 Streaming scenario: write 0x00..0xFF back-to-back while dout_rdy=1 continuously -> read sequence 0x00..0xFF in order, with no gaps after the first word, and count never exceeds 2.
REQ-036 Fill scenario: with DATA_DEPTH=16, write 17 words with dout_rdy=0 -> din_rdy=0 after the 16th, the 17th is not accepted, and count=16. One read -> din_rdy=1 next cycle and count=15.
REQ-037 Wrap scenario: with DATA_DEPTH=16, do 40 random-interleaved writes and reads -> output order matches a reference queue and count matches at every edge.
REQ-038 Mid-stream reset scenario: with count=5, pulse rst for 1 cycle -> count=0 and dout_vld=0, and the next write's word is the first word read out.
